// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range sensor controller: trigger pulse, echo timing, distance in UNIT_CYC steps.
// Define RANGER_HOLDOFF_EN to enforce HOLDOFF_CYC cycles between trig_out rising edges.
module ultrasonic_ranger #(
  parameter int DisLen      = 16,
  parameter int TRIG_CYC    = 500,
  parameter int UNIT_CYC    = 292,
  parameter int WAIT_MAX    = 100000,
  parameter int ECHO_MAX    = 1900000,
  parameter int HOLDOFF_CYC = 3000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trigger,
  input  logic            echo,
  output logic            trig_out,
  output logic            triggerSuc,
  output logic            valid,
  output logic            fail,
  output logic [DisLen:0] distance
);
  localparam int TW_MAX  = (TRIG_CYC > WAIT_MAX) ? TRIG_CYC : WAIT_MAX;
  localparam int CNT_MAX = (TW_MAX > ECHO_MAX) ? TW_MAX : ECHO_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(UNIT_CYC + 1);

  localparam logic [CW-1:0]   TRIG_LAST = CW'(TRIG_CYC);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0]   ECHO_LAST = CW'(ECHO_MAX - 1);
  localparam logic [PW-1:0]   UNIT_LAST = PW'(UNIT_CYC - 1);
  localparam logic [DisLen:0] DIST_SAT  = '1;

  if (TRIG_CYC < 1 || UNIT_CYC < 1 || WAIT_MAX < 1 || ECHO_MAX < 2 || HOLDOFF_CYC < 2) begin : g_bad_params
    $error("ultrasonic_ranger: parameter out of range");
  end

`ifdef RANGER_HOLDOFF_EN
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;
  localparam state_t AFTER_ST = HOLDOFF;
  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam logic [HW-1:0] HOFF_SAT  = HW'(HOLDOFF_CYC);
  // IDLE is reached one cycle before trigger may be sampled, so open two cycles early.
  localparam logic [HW-1:0] HOFF_OPEN = HW'(HOLDOFF_CYC - 2);
  logic [HW-1:0] hoff_reg;
`else
  typedef enum logic [1:0] {IDLE, TRIG, WAIT_ECHO, MEASURE} state_t;
  localparam state_t AFTER_ST = IDLE;
`endif

  state_t          state_reg;
  logic            echo_s1_reg, echo_s2_reg, echo_prev_reg;
  logic [CW-1:0]   cnt_reg;
  logic [PW-1:0]   presc_reg, presc_next;
  logic [DisLen:0] acc_reg, acc_next;
  logic            trig_out_reg, suc_reg, valid_reg, fail_reg;
  logic [DisLen:0] dist_reg;
  logic            echo_rise;

  assign echo_rise = echo_s2_reg & ~echo_prev_reg;

  // One echo-high cycle worth of prescaler/accumulator advance.
  always_comb begin
    presc_next = presc_reg + 1'b1;
    acc_next   = acc_reg;
    if (presc_reg == UNIT_LAST) begin
      presc_next = '0;
      if (acc_reg != DIST_SAT) acc_next = acc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      echo_s1_reg   <= 1'b0;
      echo_s2_reg   <= 1'b0;
      echo_prev_reg <= 1'b0;
      cnt_reg       <= '0;
      presc_reg     <= '0;
      acc_reg       <= '0;
      trig_out_reg  <= 1'b0;
      suc_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      fail_reg      <= 1'b0;
      dist_reg      <= '0;
`ifdef RANGER_HOLDOFF_EN
      hoff_reg      <= '0;
`endif
    end else begin
      echo_s1_reg   <= echo;
      echo_s2_reg   <= echo_s1_reg;
      echo_prev_reg <= echo_s2_reg;
      suc_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      fail_reg      <= 1'b0;
`ifdef RANGER_HOLDOFF_EN
      if (hoff_reg != HOFF_SAT) hoff_reg <= hoff_reg + 1'b1;
`endif
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            state_reg    <= TRIG;
            trig_out_reg <= 1'b1;
            cnt_reg      <= CW'(1);
`ifdef RANGER_HOLDOFF_EN
            hoff_reg     <= '0;
`endif
          end
        end
        TRIG: begin
          if (cnt_reg == TRIG_LAST) begin
            state_reg    <= WAIT_ECHO;
            trig_out_reg <= 1'b0;
            suc_reg      <= 1'b1;
            cnt_reg      <= '0;
            presc_reg    <= '0;
            acc_reg      <= '0;
          end else if (!trigger) begin
            state_reg    <= IDLE;
            trig_out_reg <= 1'b0;
            cnt_reg      <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_ECHO: begin
          // The rising-edge cycle is the first echo-high cycle, so count it here.
          if (echo_rise) begin
            state_reg <= MEASURE;
            cnt_reg   <= CW'(1);
            presc_reg <= presc_next;
            acc_reg   <= acc_next;
          end else if (cnt_reg == WAIT_LAST) begin
            state_reg <= AFTER_ST;
            fail_reg  <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        MEASURE: begin
          if (!echo_s2_reg) begin
            state_reg <= AFTER_ST;
            valid_reg <= 1'b1;
            dist_reg  <= acc_reg;
            cnt_reg   <= '0;
            presc_reg <= '0;
            acc_reg   <= '0;
          end else if (cnt_reg == ECHO_LAST) begin
            state_reg <= AFTER_ST;
            fail_reg  <= 1'b1;
            cnt_reg   <= '0;
            presc_reg <= '0;
            acc_reg   <= '0;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
            presc_reg <= presc_next;
            acc_reg   <= acc_next;
          end
        end
`ifdef RANGER_HOLDOFF_EN
        HOLDOFF: begin
          if (hoff_reg >= HOFF_OPEN) state_reg <= IDLE;
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign trig_out   = trig_out_reg;
  assign triggerSuc = suc_reg;
  assign valid      = valid_reg;
  assign fail       = fail_reg;
  assign distance   = dist_reg;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed and randomized bench for ultrasonic_ranger; expected events come from
// timing arithmetic (2-flop sync latency, floor(H/UNIT_CYC), timeouts).
module tb_ultrasonic_ranger;
  logic        clk = 1'b0;
  logic        rst, trigger, echo;
  logic        trig_out, triggerSuc, valid, fail;
  logic [16:0] distance;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0;
  int rises, last_rise, hi_cnt, suc_cnt, last_suc, val_cnt, last_val, fail_cnt, last_fail;
  int both_cnt = 0;
  logic prev_trig = 1'b0;
  int exp_dist;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .DisLen(16), .TRIG_CYC(4), .UNIT_CYC(3), .WAIT_MAX(20), .ECHO_MAX(60), .HOLDOFF_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .echo(echo),
    .trig_out(trig_out), .triggerSuc(triggerSuc), .valid(valid), .fail(fail),
    .distance(distance)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total += 1;
    assert (obs === exp) n_pass += 1;
    else begin
      n_fail += 1;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    rises = 0; hi_cnt = 0; suc_cnt = 0; val_cnt = 0; fail_cnt = 0;
    last_rise = -1; last_suc = -1; last_val = -1; last_fail = -1;
  endtask

  // Advance one clock and record output events for the cycle just entered.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (trig_out === 1'b1) begin
      hi_cnt++;
      if (prev_trig !== 1'b1) begin rises++; last_rise = cyc; end
    end
    prev_trig = trig_out;
    if (triggerSuc === 1'b1) begin suc_cnt++; last_suc = cyc; end
    if (valid === 1'b1) begin val_cnt++; last_val = cyc; end
    if (fail === 1'b1) begin fail_cnt++; last_fail = cyc; end
    if (valid === 1'b1 && fail === 1'b1) both_cnt++;
  endtask

  task automatic settle();
`ifdef RANGER_HOLDOFF_EN
    repeat (110) tick();
`else
    repeat (4) tick();
`endif
  endtask

  // Raise trigger now; expect trig_out for cycles N+1..N+4 and triggerSuc at N+5.
  task automatic do_trigger(input bit hold, input bit early_echo, output int t);
    int n0;
    clear();
    n0 = cyc;
    trigger = 1'b1;
    t = -1000;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0 && early_echo) echo = 1'b1;
      if (triggerSuc === 1'b1) begin t = cyc; break; end
    end
    if (!hold) trigger = 1'b0;
    check("trig_rise", last_rise, n0 + 1);
    check("trig_width", hi_cnt, 4);
    check("suc_cycle", t, n0 + 5);
    check("suc_once", suc_cnt, 1);
  endtask

  // Raw echo high at cycle T+d for w cycles, then a quiet tail.
  task automatic echo_txn(input int d, input int w);
    repeat (d) tick();
    echo = 1'b1;
    repeat (w) tick();
    echo = 1'b0;
    repeat (10) tick();
  endtask

  task automatic measure_check(input string tag, input int t, input int d, input int w);
    bit exp_fail;
    int ev;
    if (d + 2 >= 20) begin
      exp_fail = 1'b1; ev = t + 20;
    end else if (w >= 60) begin
      exp_fail = 1'b1; ev = t + d + 2 + 60;
    end else begin
      exp_fail = 1'b0; ev = t + d + w + 3; exp_dist = w / 3;
    end
    check({tag, "_valid_cnt"}, val_cnt, exp_fail ? 0 : 1);
    check({tag, "_fail_cnt"}, fail_cnt, exp_fail ? 1 : 0);
    check({tag, "_event_cycle"}, exp_fail ? last_fail : last_val, ev);
    check({tag, "_distance"}, distance, exp_dist);
  endtask

  initial begin
    int t, hi0, r1, d, w;
    int dir_d[4] = '{17, 18, 0, 0};
    int dir_w[4] = '{59, 10, 60, 1};
    rst = 1'b1; trigger = 1'b0; echo = 1'b0;
    exp_dist = 0;
    clear();
    repeat (3) tick();
    check("rst_trig_out", trig_out, 0);
    check("rst_triggerSuc", triggerSuc, 0);
    check("rst_valid", valid, 0);
    check("rst_fail", fail, 0);
    check("rst_distance", distance, 0);
    rst = 1'b0;
    repeat (6) tick();

    // 31 synchronised high cycles -> distance 10, no further trigger pulse
    do_trigger(1'b0, 1'b0, t);
    hi0 = hi_cnt;
    echo_txn(2, 31);
    measure_check("echo31", t, 2, 31);
    check("echo31_no_retrig", hi_cnt, hi0);
    settle();

    // No echo: wait timeout, distance retained
    do_trigger(1'b0, 1'b0, t);
    repeat (25) tick();
    check("noecho_fail_cnt", fail_cnt, 1);
    check("noecho_fail_cycle", last_fail, t + 20);
    check("noecho_valid_cnt", val_cnt, 0);
    check("noecho_distance", distance, exp_dist);
    settle();

    // Echo already high during TRIG is ignored; later 70-cycle echo times out at 60
    do_trigger(1'b0, 1'b1, t);
    repeat (3) tick();
    echo = 1'b0;
    repeat (5) tick();
    echo = 1'b1;
    repeat (70) tick();
    echo = 1'b0;
    repeat (5) tick();
    check("longecho_fail_cnt", fail_cnt, 1);
    check("longecho_fail_cycle", last_fail, t + 70);
    check("longecho_valid_cnt", val_cnt, 0);
    check("longecho_distance", distance, exp_dist);
    settle();

    // Trigger dropped after two pulse cycles aborts without triggerSuc
    clear();
    trigger = 1'b1;
    repeat (2) tick();
    trigger = 1'b0;
    tick();
    check("abort_trig_low", trig_out, 0);
    repeat (10) tick();
    check("abort_width", hi_cnt, 2);
    check("abort_no_suc", suc_cnt, 0);
    settle();

    // Reset in the middle of a measurement
    do_trigger(1'b0, 1'b0, t);
    tick();
    echo = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst_trig_out", trig_out, 0);
    check("midrst_triggerSuc", triggerSuc, 0);
    check("midrst_valid", valid, 0);
    check("midrst_fail", fail, 0);
    check("midrst_distance", distance, 0);
    rst = 1'b0;
    exp_dist = 0;
    repeat (5) tick();
    echo = 1'b0;
    repeat (20) tick();
    check("midrst_no_valid", val_cnt, 0);
    check("midrst_no_fail", fail_cnt, 0);
    settle();

    // Boundary cases then random echo delay/width
    for (int k = 0; k < 12; k++) begin
      if (k < 4) begin
        d = dir_d[k]; w = dir_w[k];
      end else begin
        d = int'($urandom_range(0, 22)); w = int'($urandom_range(1, 72));
      end
      do_trigger(1'b0, 1'b0, t);
      echo_txn(d, w);
      $display("txn %0d: delay=%0d width=%0d valid=%0d fail=%0d distance=%0d", k, d, w, val_cnt, fail_cnt, distance);
      measure_check($sformatf("txn%0d", k), t, d, w);
      settle();
    end

    // Trigger held continuously: spacing of consecutive trig_out rises
    do_trigger(1'b1, 1'b0, t);
    r1 = last_rise;
    echo_txn(1, 9);
    for (int i = 0; i < 150 && rises < 2; i++) tick();
    trigger = 1'b0;
    check("held_valid_cnt", val_cnt, 1);
    check("held_rises", rises, 2);
`ifdef RANGER_HOLDOFF_EN
    check("held_rise_spacing", last_rise - r1, 100);
`else
    check("held_rise_after_valid", last_rise, last_val + 1);
    check("held_valid_cycle", last_val, r1 + 4 + 1 + 9 + 3);
`endif
    repeat (10) tick();

    check("valid_fail_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion, expected summary before timeout");
    $fatal(1, "watchdog timeout");
  end
endmodule

// File: doc/ultrasonic_ranger.md
ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 SHALL have parameters: DisLen, 16, distance MSB index (distance is DisLen+1 bits).
REQ-002 SHALL have parameters: TRIG_CYC, 500, sensor trigger pulse width in cycles; UNIT_CYC, 292, echo cycles per distance unit; WAIT_MAX, 100000, max cycles from triggerSuc to echo rise; ECHO_MAX, 1900000, max echo-high cycles; HOLDOFF_CYC, 3000000, min cycles between trig_out pulses.
REQ-003 SHALL have ports: clk  input  1  system clock, single clock domain.
REQ-004 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: trigger  input  1  measurement request level from controller, held until triggerSuc.
REQ-006 SHALL have ports: echo  input  1  raw sensor echo, asynchronous.
REQ-007 SHALL have ports: trig_out  output  1  sensor trigger pulse.
REQ-008 SHALL have ports: triggerSuc  output  1  one-cycle pulse, trigger pulse completed.
REQ-009 SHALL have ports: valid  output  1  one-cycle pulse, distance updated.
REQ-010 SHALL have ports: fail  output  1  one-cycle pulse, measurement timed out.
REQ-011 SHALL have ports: distance  output  DisLen+1  last measured distance, unsigned.

Function
REQ-012 SHALL synchronise echo through two flops; all echo edge detection uses the second flop versus its previous value.
REQ-013 SHALL implement states IDLE, TRIG, WAIT_ECHO, MEASURE (plus HOLDOFF when enabled, REQ-026).
REQ-014 IDLE: trigger sampled high at cycle N -> TRIG; trig_out high cycles N+1..N+TRIG_CYC exactly.
REQ-015 TRIG: after the last high cycle, triggerSuc high for exactly one cycle (N+TRIG_CYC+1), state -> WAIT_ECHO.
REQ-016 TRIG: trigger sampled low before pulse end -> trig_out low next cycle, state -> IDLE, no triggerSuc.
REQ-017 WAIT_ECHO: synchronised echo rising edge -> MEASURE; echo already high on entry is ignored until it falls and rises again.
REQ-018 WAIT_ECHO: WAIT_MAX cycles without rising edge -> fail pulse, distance unchanged, -> IDLE.
REQ-019 MEASURE: prescaler counts 0..UNIT_CYC-1 per echo-high cycle; each wrap increments distance accumulator, saturating at all-ones.
REQ-020 MEASURE: synchronised falling edge -> distance = floor(H/UNIT_CYC) (H = synchronised high cycles), valid pulse same cycle distance updates, -> IDLE.
REQ-021 MEASURE: echo high ECHO_MAX cycles -> fail pulse, distance unchanged, -> IDLE.
REQ-022 valid and fail SHALL never be high in the same cycle; trigger ignored outside IDLE.
REQ-023 trig_out, triggerSuc, valid, fail, distance SHALL be registered outputs.

Reset
REQ-024 rst high at any clock edge, including mid-pulse or mid-measure -> next cycle: state IDLE, trig_out 0, triggerSuc 0, valid 0, fail 0, distance 0, all counters 0, synchroniser flops 0.
REQ-025 No pulse output SHALL be generated for a measurement interrupted by reset.

Configuration
REQ-026 Macro RANGER_HOLDOFF_EN defined: after valid or fail, enter HOLDOFF; trigger ignored until HOLDOFF_CYC cycles elapsed since previous trig_out rise, then IDLE; counter width sized for HOLDOFF_CYC.
REQ-027 Macro RANGER_HOLDOFF_EN undefined: no HOLDOFF state or counter; IDLE accepts trigger the cycle after valid/fail.

Verification (bench parameters TRIG_CYC=4, UNIT_CYC=3, WAIT_MAX=20, ECHO_MAX=60, HOLDOFF_CYC=100)
REQ-028 trigger high at cycle 10 -> trig_out high cycles 11..14, triggerSuc high cycle 15 only.
REQ-029 echo high 31 raw cycles after triggerSuc -> valid one cycle, distance=10, trig_out stays low.
REQ-030 no echo after triggerSuc -> fail one cycle 20 cycles later, distance keeps previous value 10.
REQ-031 echo held high 70 cycles -> fail after 60 high cycles, no valid; echo high before triggerSuc ignored.
REQ-032 trigger dropped at cycle 12 -> trig_out low cycle 13, no triggerSuc; rst during MEASURE -> all outputs 0 next cycle, no valid.
REQ-033 RANGER_HOLDOFF_EN defined: trigger held continuously -> consecutive trig_out rises exactly 100 cycles apart; undefined -> next rise one cycle after valid plus one.
